// File: rtl/vga_controller_pkg.sv
// Shared helpers for the VGA controller: raster totals and counter widths.
package vga_controller_pkg;

  // Total length of a raster dimension (active + front porch + sync + back porch).
  function automatic int unsigned raster_total(input int unsigned act,
                                               input int unsigned fp,
                                               input int unsigned sp,
                                               input int unsigned bp);
    return act + fp + sp + bp;
  endfunction

  // Counter width able to hold 0..tot-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned tot);
    return (tot < 2) ? 1 : $clog2(tot);
  endfunction

endpackage

// File: rtl/vga_controller_timing.sv
// Horizontal/vertical raster counters with active, sync-window and end-of-frame decode.
module vga_controller_timing
  import vga_controller_pkg::*;
#(
  parameter int X_HOR = 800,
  parameter int X_HFP = 40,
  parameter int X_HSP = 128,
  parameter int X_HBP = 88,
  parameter int X_VER = 600,
  parameter int X_VFP = 1,
  parameter int X_VSP = 4,
  parameter int X_VBP = 23
) (
  input  logic clock,
  input  logic rst,
  output logic active,
  output logic hs_win,
  output logic vs_win,
  output logic frame
);

  localparam int HTOT = int'(raster_total(X_HOR, X_HFP, X_HSP, X_HBP));
  localparam int VTOT = int'(raster_total(X_VER, X_VFP, X_VSP, X_VBP));
  localparam int HW   = int'(cnt_width(HTOT));
  localparam int VW   = int'(cnt_width(VTOT));

  // Decode points; every sync window ends at least one count before the wrap.
  localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(X_HOR);
  localparam logic [HW-1:0] HS_BEG = HW'(X_HOR + X_HFP);
  localparam logic [HW-1:0] HS_END = HW'(X_HOR + X_HFP + X_HSP);
  localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(X_VER);
  localparam logic [VW-1:0] VS_BEG = VW'(X_VER + X_VFP);
  localparam logic [VW-1:0] VS_END = VW'(X_VER + X_VFP + X_VSP);

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          h_last;
  logic          v_last;

  assign h_last = (hc == H_LAST);
  assign v_last = (vc == V_LAST);

  // Raster position: hc runs every cycle, vc steps on each line wrap.
  always_ff @(posedge clock) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (h_last) begin
      hc <= '0;
      vc <= v_last ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  assign active = (hc < H_ACT) && (vc < V_ACT);
  assign hs_win = (hc >= HS_BEG) && (hc < HS_END);
  assign vs_win = (vc >= VS_BEG) && (vc < VS_END);
  assign frame  = h_last && v_last;

endmodule

// File: rtl/vga_controller.sv
// Streaming pixel-to-VGA output: ready/valid pixel intake, registered RGB/HS/VS.
module vga_controller
  import vga_controller_pkg::*;
#(
  parameter int FREQ  = 40_000_000,
  parameter int X_HOR = 800,
  parameter int X_HFP = 40,
  parameter int X_HSP = 128,
  parameter int X_HBP = 88,
  parameter int X_VER = 600,
  parameter int X_VFP = 1,
  parameter int X_VSP = 4,
  parameter int X_VBP = 23,
  parameter int RB    = 5,
  parameter int GB    = 6,
  parameter int BB    = 5
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          valid,
  input  logic [RB-1:0] r_in,
  input  logic [GB-1:0] g_in,
  input  logic [BB-1:0] b_in,
  output logic          ready,
  output logic          frame,
  output logic [RB-1:0] r_out,
  output logic [GB-1:0] g_out,
  output logic [BB-1:0] b_out,
  output logic          hs,
  output logic          vs
);

  // FREQ only documents the intended pixel clock; reject nonsensical settings early.
  if (FREQ < 1 || X_HOR < 1 || X_HFP < 1 || X_HSP < 1 || X_HBP < 1 ||
      X_VER < 1 || X_VFP < 1 || X_VSP < 1 || X_VBP < 1) begin : g_bad_params
    $error("vga_controller: all timing parameters and FREQ must be >= 1");
  end

  logic          active_p0;
  logic          hs_win_p0;
  logic          vs_win_p0;
  logic          frame_p0;
  logic          vld_p0;
  logic [RB-1:0] r_p1;
  logic [GB-1:0] g_p1;
  logic [BB-1:0] b_p1;
  logic          hs_p1;
  logic          vs_p1;

  vga_controller_timing #(
    .X_HOR(X_HOR), .X_HFP(X_HFP), .X_HSP(X_HSP), .X_HBP(X_HBP),
    .X_VER(X_VER), .X_VFP(X_VFP), .X_VSP(X_VSP), .X_VBP(X_VBP)
  ) u_timing (
    .clock  (clock),
    .rst    (resetn),
    .active (active_p0),
    .hs_win (hs_win_p0),
    .vs_win (vs_win_p0),
    .frame  (frame_p0)
  );

  // Stage p0: raster decode and handshake, both held low while in reset.
  assign ready  = active_p0 & ~resetn;
  assign frame  = frame_p0 & ~resetn;
  assign vld_p0 = ready & valid;

  // Stage p1: output registers; a missing pixel or blanking yields black.
  always_ff @(posedge clock) begin
    if (resetn) begin
      r_p1  <= '0;
      g_p1  <= '0;
      b_p1  <= '0;
      hs_p1 <= 1'b0;
      vs_p1 <= 1'b0;
    end else begin
      r_p1  <= vld_p0 ? r_in : '0;
      g_p1  <= vld_p0 ? g_in : '0;
      b_p1  <= vld_p0 ? b_in : '0;
      hs_p1 <= hs_win_p0;
      vs_p1 <= vs_win_p0;
    end
  end

  assign r_out = r_p1;
  assign g_out = g_p1;
  assign b_out = b_p1;
  assign hs    = hs_p1;
  assign vs    = vs_p1;

endmodule

// File: tb/tb_vga_controller.sv
// Self-checking bench for vga_controller with a small raster and random pixels.
module tb_vga_controller;

  localparam int HOR = 10, HFP = 2, HSP = 4, HBP = 1;
  localparam int VER = 10, VFP = 3, VSP = 6, VBP = 2;
  localparam int HTOT = HOR + HFP + HSP + HBP;
  localparam int VTOT = VER + VFP + VSP + VBP;
  localparam int FTOT = HTOT * VTOT;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       valid = 1'b0;
  logic [4:0] r_in = '0;
  logic [5:0] g_in = '0;
  logic [4:0] b_in = '0;
  logic       ready, frame, hs, vs;
  logic [4:0] r_out;
  logic [5:0] g_out;
  logic [4:0] b_out;

  int checks = 0;
  int errors = 0;

  vga_controller #(
    .X_HOR(HOR), .X_HFP(HFP), .X_HSP(HSP), .X_HBP(HBP),
    .X_VER(VER), .X_VFP(VFP), .X_VSP(VSP), .X_VBP(VBP),
    .RB(5), .GB(6), .BB(5)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .valid  (valid),
    .r_in   (r_in),
    .g_in   (g_in),
    .b_in   (b_in),
    .ready  (ready),
    .frame  (frame),
    .r_out  (r_out),
    .g_out  (g_out),
    .b_out  (b_out),
    .hs     (hs),
    .vs     (vs)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference raster: position p = cycles since (0,0) within a frame.
  function automatic bit in_active(input int p);
    return ((p % HTOT) < HOR) && ((p / HTOT) < VER);
  endfunction
  function automatic bit in_hsync(input int p);
    return ((p % HTOT) >= HOR + HFP) && ((p % HTOT) < HOR + HFP + HSP);
  endfunction
  function automatic bit in_vsync(input int p);
    return ((p / HTOT) >= VER + VFP) && ((p / HTOT) < VER + VFP + VSP);
  endfunction

  int         mp = 0;
  logic [4:0] er = '0;
  logic [5:0] eg = '0;
  logic [4:0] eb = '0;
  logic       ehs = 1'b0;
  logic       evs = 1'b0;

  // Every cycle: compare DUT against the model, then advance the model one edge.
  always @(negedge clock) begin
    chk("ready", ready, resetn ? 1'b0 : in_active(mp));
    chk("frame", frame, resetn ? 1'b0 : (mp == FTOT - 1));
    chk("r_out", r_out, er);
    chk("g_out", g_out, eg);
    chk("b_out", b_out, eb);
    chk("hs", hs, ehs);
    chk("vs", vs, evs);
    if (resetn) begin
      er = '0; eg = '0; eb = '0; ehs = 1'b0; evs = 1'b0;
      mp = 0;
    end else begin
      if (in_active(mp) && valid) begin
        er = r_in; eg = g_in; eb = b_in;
      end else begin
        er = '0; eg = '0; eb = '0;
      end
      ehs = in_hsync(mp);
      evs = in_vsync(mp);
      mp = (mp + 1) % FTOT;
    end
  end

  task automatic drive(input bit v);
    valid = v;
    r_in  = 5'($urandom);
    g_in  = 6'($urandom);
    b_in  = 5'($urandom);
  endtask

  // Counts cycles from release until frame pulses (cycle of release = 0).
  task automatic wait_frame(input string name, input int mode);
    int  cyc;
    bit  found;
    cyc = 0;
    found = 0;
    for (int i = 0; i < 2 * FTOT; i++) begin
      @(negedge clock);
      if (i == 0) chk({name, "_ready0"}, ready, 1'b1);
      if (frame === 1'b1) begin
        found = 1;
        break;
      end
      cyc++;
      @(posedge clock); #1;
      drive(mode == 1 ? 1'b1 : (mode == 0 ? 1'b0 : 1'($urandom)));
    end
    chk(name, found ? cyc : -1, FTOT - 1);
  endtask

  initial begin
    int nrdy, nx, nhs, nvs;

    // Reset held for a few cycles, then released.
    resetn = 1'b1;
    drive(1'b1);
    repeat (4) @(posedge clock);
    #1 resetn = 1'b0;
    drive(1'b0);
    wait_frame("first_frame", 2);

    // A full frame with valid always high.
    nrdy = 0; nx = 0; nhs = 0; nvs = 0;
    for (int i = 0; i < FTOT; i++) begin
      @(posedge clock); #1;
      drive(1'b1);
      @(negedge clock);
      nrdy += int'(ready);
      nx   += int'(ready && valid);
      nhs  += int'(hs);
      nvs  += int'(vs);
      if (i == FTOT - 1) chk("frame_period", frame, 1'b1);
    end
    chk("ready_per_frame", nrdy, 100);
    chk("pixels_per_frame", nx, 100);
    chk("hs_cycles", nhs, 4 * 21);
    chk("vs_cycles", nvs, 102);

    // A frame with random valid gaps.
    for (int i = 0; i < FTOT; i++) begin
      @(posedge clock); #1;
      drive(1'($urandom));
      @(negedge clock);
      if (i == FTOT - 1) chk("frame_period_rand", frame, 1'b1);
    end

    // Valid low through part of the active area.
    for (int i = 0; i < 3 * HTOT + 5; i++) begin
      @(posedge clock); #1;
      drive(1'b0);
    end

    // Mid-line reset for three cycles, then restart.
    @(posedge clock); #1;
    resetn = 1'b1;
    drive(1'b1);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b0;
    drive(1'b1);
    wait_frame("frame_after_reset", 1);

    repeat (5) begin
      @(posedge clock); #1;
      drive(1'($urandom));
    end
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_controller.md
# vga_controller

Streaming pixel-to-VGA output block (module `vga`). It generates horizontal and vertical raster timing from a single pixel clock. It pulls RGB pixels from an upstream source with a ready/valid handshake during the active area and drives registered RGB, HS and VS to the display DAC/pins. It sits between a frame source (framebuffer reader or pattern generator) and the board's VGA connector.

## Interface
Parameters:
- `FREQ`, 40_000_000: pixel clock frequency in Hz; informational only, no logic depends on it.
- `X_HOR`, 800: active pixels per line.
- `X_HFP`, 40: horizontal front porch, in pixels.
- `X_HSP`, 128: horizontal sync pulse width, in pixels.
- `X_HBP`, 88: horizontal back porch, in pixels.
- `X_VER`, 600: active lines per frame.
- `X_VFP`, 1: vertical front porch, in lines.
- `X_VSP`, 4: vertical sync width, in lines.
- `X_VBP`, 23: vertical back porch, in lines.
- `RB` / `GB` / `BB`, 5 / 6 / 5: red / green / blue channel widths.

Ports:
- `clock`  in  1  pixel clock; everything is on the rising edge.
- `resetn`  in  1  synchronous, active-high reset; 1 = reset asserted, despite the name.
- `valid`  in  1  upstream pixel on `r_in`/`g_in`/`b_in` is valid.
- `r_in` / `g_in` / `b_in`  in  RB / GB / BB  upstream pixel.
- `ready`  out  1  block consumes a pixel this cycle (active area).
- `frame`  out  1  one-cycle pulse on the last cycle of each frame.
- `r_out` / `g_out` / `b_out`  out  RB / GB / BB  pixel to display.
- `hs`  out  1  horizontal sync, active-high.
- `vs`  out  1  vertical sync, active-high.

## Operation
- Derived totals: HTOT = X_HOR+X_HFP+X_HSP+X_HBP and VTOT = X_VER+X_VFP+X_VSP+X_VBP. All timing parameters must be ≥1.
- Counters `hc` and `vc` are unsigned, each `$clog2(TOT)` bits wide.
  - `hc` counts 0..HTOT-1 and wraps to 0.
  - `vc` increments when `hc` wraps, and itself wraps to 0 after VTOT-1.
- Active area: `hc < X_HOR && vc < X_VER`.
- `ready` is combinational and equals active. It does not depend on `valid`.
- A pixel transfers when `valid && ready`. If `ready && !valid`, the block outputs black (zeros). There is no stall and no buffering; the raster never waits.
- Next RGB value:
  - transfer: the input pixel;
  - otherwise, including all blanking: 0.
- Next `hs` = 1 when `X_HOR+X_HFP ≤ hc < X_HOR+X_HFP+X_HSP`.
- Next `vs` = 1 when `X_VER+X_VFP ≤ vc < X_VER+X_VFP+X_VSP`. `vs` spans whole lines, with edges at `hc` = 0.
- `frame` is combinational: 1 when `hc == HTOT-1 && vc == VTOT-1`. The following cycle is pixel (0,0) with `ready` = 1.

## Timing
- RGB, `hs` and `vs` are registered with one cycle of latency relative to the counter state and `ready`. The pixel accepted in cycle N appears on `r_out`/`g_out`/`b_out` in cycle N+1, aligned with its `hs`/`vs`.
- While `resetn` = 1:
  - `hc` = `vc` = 0;
  - `r_out`/`g_out`/`b_out` = 0, `hs` = 0, `vs` = 0;
  - `ready` = 0 and `frame` = 0 (both gated by reset).
- First cycle after reset deasserts: `hc` = `vc` = 0 and `ready` = 1.
- Reset asserted mid-frame takes effect at the next edge. Any in-flight output is dropped to 0 and the raster restarts at (0,0).
- Frame period is exactly HTOT·VTOT cycles. `ready` is high for exactly X_HOR·X_VER cycles per frame.
- Wrap points:
  - `hc` = HTOT-1 → 0;
  - `vc` = VTOT-1 → 0 only at `hc` = HTOT-1;
  - `frame` and the `vc` wrap occur on the same edge.

## Structure
- Package `vga_pkg`: a helper function computing counter widths and totals from the parameters.
- Sub-module `vga_timing`: the `hc`/`vc` counters plus the active, hsync-window, vsync-window and `frame` decode.
- Top `vga`: the handshake, RGB mux/registers and reset gating.

## Test plan
Use small parameters: HOR=10, HFP=2, HSP=4, HBP=1, VER=10, VFP=3, VSP=6, VBP=2, with RB=5, GB=6, BB=5. This gives HTOT=17, VTOT=21, and a 357-cycle frame.
- Reset then release → `ready` = 1 on the first cycle. `frame` pulses every 357 cycles, first on cycle 356. `r_out`/`g_out`/`b_out`/`hs`/`vs` are 0 during reset.
- Line timing → `ready` is high 10 of every 17 cycles on lines 0–9. `hs` is high for 4 cycles, rising 13 cycles (12+1 latency) after the line start.
- Frame timing → `vs` is high for 6·17 = 102 cycles, starting on the first cycle of line 13, +1 cycle latency.
- After `frame`, drive `valid` = 1 with random RGB updated whenever `ready` → each accepted pixel appears on the outputs exactly 1 cycle later. Outputs are 0 on every blanking cycle. 100 pixels are transferred per frame.
- Drive `valid` = 0 during the active area → outputs are 0, `ready` stays 1, and the raster is unaffected. Extra pixels presented past the active area are never emitted.
- Assert reset mid-line for 3 cycles → all outputs are 0 during reset. The raster restarts at (0,0), and the next `frame` pulse comes 357 cycles after release.
